// File: rtl/jogador_pkg.sv
// Shared definitions for the automatic player of the memory-sequence game.
// Holds the state codes, the ROM depth, the default timing constants and the
// helper used to corrupt one play when JOGADOR_ERRO_INJ_EN is defined.
package jogador_pkg;

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        INICIA    = 4'd1,
        PREPARA   = 4'd2,
        APRESENTA = 4'd3,
        SOLTA     = 4'd4,
        AGUARDA   = 4'd5,
        FIM_OK    = 4'd6,
        FIM_ERRO  = 4'd7
    } estado_t;

    localparam int ROM_DEPTH = 16;

    localparam int PREP_CYC_PADRAO    = 2;
    localparam int HOLD_CYC_PADRAO    = 3;
    localparam int GAP_CYC_PADRAO     = 1;
    localparam int TIMEOUT_CYC_PADRAO = 64;
    localparam int ERR_POS_PADRAO     = 5;

    // Wide enough for every phase length, including the timeout wait.
    localparam int CONT_W = 16;

    // Rotates a one-hot play one position to the left (0010 -> 0100).
    function automatic logic [3:0] rotaciona_esq(input logic [3:0] valor);
        return {valor[2:0], valor[3]};
    endfunction

endpackage

// File: rtl/sequencia_rom_16x4.sv
// Combinational table of the 16 one-hot plays replayed to the game.
module sequencia_rom_16x4
    import jogador_pkg::*;
(
    input  logic [$clog2(ROM_DEPTH)-1:0] endereco,
    output logic [3:0]                   dado
);

    // Fixed play sequence, one one-hot switch value per address.
    always_comb begin
        dado = 4'b0000;
        case (endereco)
            4'd0:    dado = 4'b0001;
            4'd1:    dado = 4'b0010;
            4'd2:    dado = 4'b0100;
            4'd3:    dado = 4'b1000;
            4'd4:    dado = 4'b0100;
            4'd5:    dado = 4'b0010;
            4'd6:    dado = 4'b0001;
            4'd7:    dado = 4'b0001;
            4'd8:    dado = 4'b0010;
            4'd9:    dado = 4'b0010;
            4'd10:   dado = 4'b0100;
            4'd11:   dado = 4'b0100;
            4'd12:   dado = 4'b1000;
            4'd13:   dado = 4'b1000;
            4'd14:   dado = 4'b0001;
            4'd15:   dado = 4'b0100;
            default: dado = 4'b0000;
        endcase
    end

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: pulses iniciar, replays the stored sequence on chaves with
// fixed hold/gap timing, then waits for the game verdict or a timeout.
// Optional feature: define JOGADOR_ERRO_INJ_EN to corrupt the play at ERR_POS
// (rotated left by one) so the game's loss path gets exercised.
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int N           = ROM_DEPTH,
    parameter int PREP_CYC    = PREP_CYC_PADRAO,
    parameter int HOLD_CYC    = HOLD_CYC_PADRAO,
    parameter int GAP_CYC     = GAP_CYC_PADRAO,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_PADRAO,
    parameter int ERR_POS     = ERR_POS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       pronto,
    input  logic       acertou,
    input  logic       errou,
    output logic       iniciar,
    output logic [3:0] chaves,
    output logic       fim,
    output logic       sucesso,
    output logic       timeout,
    output logic [3:0] db_indice,
    output logic [3:0] db_estado
);

    estado_t             estado, prox_estado;
    logic [3:0]          indice, prox_indice;
    logic [CONT_W-1:0]   cont, prox_cont;
    logic                prox_timeout;
    logic                vitoria;
    logic                ultima;
    logic [3:0]          rom_dado;
    logic [3:0]          jogada;

    assign vitoria   = pronto & acertou & ~errou;
    assign ultima    = (indice == 4'(N - 1));
    assign db_estado = estado;
    assign db_indice = indice;

    // The ROM is addressed with the next index so chaves can be registered.
    sequencia_rom_16x4 u_rom (
        .endereco (prox_indice),
        .dado     (rom_dado)
    );

`ifdef JOGADOR_ERRO_INJ_EN
    assign jogada = (prox_indice == 4'(ERR_POS)) ? rotaciona_esq(rom_dado) : rom_dado;
`else
    assign jogada = rom_dado;
`endif

    // Next-state logic: one shared counter times every phase, early verdicts win.
    always_comb begin
        prox_estado  = estado;
        prox_indice  = indice;
        prox_cont    = cont;
        prox_timeout = timeout;
        case (estado)
            OCIOSO, FIM_OK, FIM_ERRO: begin
                if (jogar) begin
                    prox_estado  = INICIA;
                    prox_indice  = 4'd0;
                    prox_cont    = '0;
                    prox_timeout = 1'b0;
                end
            end
            INICIA: begin
                prox_estado  = PREPARA;
                prox_indice  = 4'd0;
                prox_cont    = '0;
                prox_timeout = 1'b0;
            end
            PREPARA: begin
                if (pronto) begin
                    prox_estado = FIM_ERRO;
                end else if (cont == CONT_W'(PREP_CYC - 1)) begin
                    prox_estado = APRESENTA;
                    prox_cont   = '0;
                end else begin
                    prox_cont = cont + 1'b1;
                end
            end
            APRESENTA: begin
                if (pronto) begin
                    prox_estado = FIM_ERRO;
                end else if (cont == CONT_W'(HOLD_CYC - 1)) begin
                    prox_estado = SOLTA;
                    prox_cont   = '0;
                end else begin
                    prox_cont = cont + 1'b1;
                end
            end
            SOLTA: begin
                if (pronto) begin
                    prox_estado = (vitoria && ultima) ? FIM_OK : FIM_ERRO;
                end else if (cont == CONT_W'(GAP_CYC - 1)) begin
                    prox_cont = '0;
                    if (ultima) begin
                        prox_estado = AGUARDA;
                    end else begin
                        prox_estado = APRESENTA;
                        prox_indice = indice + 4'd1;
                    end
                end else begin
                    prox_cont = cont + 1'b1;
                end
            end
            AGUARDA: begin
                if (pronto) begin
                    prox_estado = vitoria ? FIM_OK : FIM_ERRO;
                end else if (cont == CONT_W'(TIMEOUT_CYC)) begin
                    prox_estado  = FIM_ERRO;
                    prox_timeout = 1'b1;
                end else begin
                    prox_cont = cont + 1'b1;
                end
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
    end

    // State, counters and all outputs registered; reset drops them at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= OCIOSO;
            indice  <= 4'd0;
            cont    <= '0;
            iniciar <= 1'b0;
            chaves  <= 4'b0000;
            fim     <= 1'b0;
            sucesso <= 1'b0;
            timeout <= 1'b0;
        end else begin
            estado  <= prox_estado;
            indice  <= prox_indice;
            cont    <= prox_cont;
            iniciar <= (prox_estado == INICIA);
            chaves  <= (prox_estado == APRESENTA) ? jogada : 4'b0000;
            fim     <= (prox_estado == FIM_OK) || (prox_estado == FIM_ERRO);
            sucesso <= (prox_estado == FIM_OK);
            timeout <= prox_timeout;
        end
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a directed table of game responses plus
// randomized runs, every cycle compared against a timeline model.
module tb_jogador_automatico;

    localparam int N  = 16;
    localparam int P  = 2;
    localparam int H  = 3;
    localparam int G  = 1;
    localparam int TO = 64;
    localparam int A  = 2 + P + N * (H + G);

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       iniciar;
    logic [3:0] chaves;
    logic       fim;
    logic       sucesso;
    logic       timeout;
    logic [3:0] db_indice;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    logic [3:0] rom_ref [16];

    typedef struct {
        int tp;
        bit ac;
        bit er;
        int jt;
        int exp_fim;
        bit exp_ok;
        bit exp_to;
        int exp_idx;
    } vetor_t;

    vetor_t tabela [12];

    always #5 clock = ~clock;

    jogador_automatico #(
        .N(N), .PREP_CYC(P), .HOLD_CYC(H), .GAP_CYC(G), .TIMEOUT_CYC(TO), .ERR_POS(5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .jogar     (jogar),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .iniciar   (iniciar),
        .chaves    (chaves),
        .fim       (fim),
        .sucesso   (sucesso),
        .timeout   (timeout),
        .db_indice (db_indice),
        .db_estado (db_estado)
    );

    task automatic checkOutput(input string nome, input int t,
                               input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0d got=%h exp=%h", nome, t, got, exp);
        end
    endtask

    // Outcome of a run where pronto is high only during interval tp after jogar.
    function automatic void modelo(input int tp, input bit ac, input bit er,
                                   output int e, output bit ok, output bit to, output int idx);
        int rel;
        int j;
        int off;
        if (tp < 2 || tp > A + TO) begin
            e = A + TO + 1; ok = 0; to = 1; idx = N - 1;
        end else if (tp < 2 + P) begin
            e = tp + 1; ok = 0; to = 0; idx = 0;
        end else if (tp < A) begin
            rel = tp - 2 - P;
            j   = rel / (H + G);
            off = rel % (H + G);
            e = tp + 1; to = 0; idx = j;
            ok = (off >= H) && (j == N - 1) && ac && !er;
        end else begin
            e = tp + 1; to = 0; idx = N - 1;
            ok = ac && !er;
        end
    endfunction

    // Expected {iniciar, chaves, fim, sucesso, timeout, db_indice, db_estado}.
    function automatic logic [15:0] esperado(input int t, input int e, input bit ok,
                                             input bit to, input int idx);
        int rel;
        int j;
        int off;
        logic       ini;
        logic [3:0] ch;
        logic [3:0] ix;
        logic [3:0] st;
        ini = 1'b0; ch = 4'd0; ix = 4'd0; st = 4'd0;
        if (t >= e) return {1'b0, 4'd0, 1'b1, ok, to, 4'(idx), ok ? 4'd6 : 4'd7};
        if (t == 1) begin
            ini = 1'b1; st = 4'd1;
        end else if (t < 2 + P) begin
            st = 4'd2;
        end else if (t < A) begin
            rel = t - 2 - P;
            j   = rel / (H + G);
            off = rel % (H + G);
            ix  = 4'(j);
            if (off < H) begin
                st = 4'd3; ch = rom_ref[j];
            end else begin
                st = 4'd4;
            end
        end else begin
            st = 4'd5; ix = 4'(N - 1);
        end
        return {ini, ch, 3'b000, ix, st};
    endfunction

    // One run: pulse jogar, answer with pronto at tp, optional stray jogar at jt,
    // optional asynchronous reset at rt; checks every cycle against the model.
    task automatic applyStimulus(input int tp, input bit ac, input bit er,
                                 input int jt, input int rt, output int fim_t);
        int e;
        int idx;
        bit ok;
        bit to;
        modelo(tp, ac, er, e, ok, to, idx);
        fim_t = -1;
        @(negedge clock);
        jogar = 1'b1; pronto = 1'b0; acertou = ac; errou = er;
        @(negedge clock);
        jogar = 1'b0;
        for (int t = 1; t <= e + 2; t++) begin
            if (t > 1) @(negedge clock);
            checkOutput("ciclo", t, {iniciar, chaves, fim, sucesso, timeout, db_indice, db_estado},
                        esperado(t, e, ok, to, idx));
            if (fim && fim_t < 0) fim_t = t;
            if (t == rt) begin
                reset = 1'b1;
                #1;
                checkOutput("reset_assinc", t,
                            {iniciar, chaves, fim, sucesso, timeout, db_indice, db_estado}, 16'h0000);
                @(negedge clock);
                reset = 1'b0;
                break;
            end
            pronto = (t == tp);
            jogar  = (t == jt);
        end
        pronto = 1'b0; jogar = 1'b0;
    endtask

    initial begin
        int fim_t;
        int tp;
        int jt;
        int e;
        int idx;
        bit ok;
        bit to;
        bit ac;
        bit er;

        rom_ref = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                    4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
`ifdef JOGADOR_ERRO_INJ_EN
        rom_ref[5] = 4'b0100;
`endif

        //               tp   ac er  jt  fim ok to idx
        tabela[0]  = '{  70, 1, 0,  10,  71, 1, 0, 15};
        tabela[1]  = '{  17, 0, 1,  -1,  18, 0, 0,  3};
        tabela[2]  = '{  -1, 0, 0,  -1, 133, 0, 1, 15};
        tabela[3]  = '{   4, 1, 0,  -1,   5, 0, 0,  0};
        tabela[4]  = '{   2, 0, 1,  -1,   3, 0, 0,  0};
        tabela[5]  = '{  67, 1, 0,  -1,  68, 1, 0, 15};
        tabela[6]  = '{  66, 1, 0,  -1,  67, 0, 0, 15};
        tabela[7]  = '{  80, 1, 1,  -1,  81, 0, 0, 15};
        tabela[8]  = '{ 100, 0, 0,  -1, 101, 0, 0, 15};
        tabela[9]  = '{ 132, 1, 0,  -1, 133, 1, 0, 15};
        tabela[10] = '{   1, 0, 1,  -1, 133, 0, 1, 15};
        tabela[11] = '{  63, 1, 0,  -1,  64, 0, 0, 14};

        reset = 1'b1; jogar = 1'b0; pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
        #12;
        checkOutput("reset", 0, {iniciar, chaves, fim, sucesso, timeout, db_indice, db_estado}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ocioso", 0, {iniciar, chaves, fim, sucesso, timeout, db_indice, db_estado}, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tabela[i].tp, tabela[i].ac, tabela[i].er, tabela[i].jt, -1, fim_t);
            checkOutput("fim_ciclo", i, 16'(fim_t), 16'(tabela[i].exp_fim));
            checkOutput("resultado", i, {8'd0, db_indice, 1'b0, sucesso, timeout, fim},
                        {8'd0, 4'(tabela[i].exp_idx), 1'b0, tabela[i].exp_ok, tabela[i].exp_to, 1'b1});
        end

        // Reset in the middle of play 7, then a clean run must start from index 0.
        applyStimulus(-1, 0, 0, -1, 2 + P + 7 * (H + G) + 1, fim_t);
        checkOutput("apos_reset", 0, {iniciar, chaves, fim, sucesso, timeout, db_indice, db_estado}, 16'h0000);
        applyStimulus(70, 1, 0, -1, -1, fim_t);
        checkOutput("reinicio_fim", 0, 16'(fim_t), 16'd71);

        for (int r = 0; r < 20; r++) begin
            tp = int'($urandom_range(1, A + TO + 8));
            if ($urandom_range(0, 4) == 0) tp = -1;
            ac = 1'($urandom_range(0, 1));
            er = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                tp = int'($urandom_range(A, A + TO)); ac = 1'b1; er = 1'b0;
            end
            modelo(tp, ac, er, e, ok, to, idx);
            jt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, e - 1)) : -1;
            applyStimulus(tp, ac, er, jt, -1, fim_t);
            checkOutput("aleat_fim", r, 16'(fim_t), 16'(e));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Automatic player for the memory-sequence game circuit (`circuito_exp5`). It drives the game's `iniciar` and one-hot `chaves` inputs and reads back `pronto`, `acertou` and `errou`. It replays a stored 16-entry sequence as timed switch presses, then reports whether the game declared a win. It sits beside the game on the board or in the system bench, as the initiator on the game's player-side interface, and allows hands-free regression of the game FSM.

## Interface
Parameters:
- `N`, 16: number of plays replayed (1..16).
- `PREP_CYC`, 2: idle cycles with `chaves`=0 after the `iniciar` pulse.
- `HOLD_CYC`, 3: cycles each play value is held on `chaves`.
- `GAP_CYC`, 1: cycles `chaves`=0 between plays.
- `TIMEOUT_CYC`, 64: maximum cycles to wait for `pronto` after the last play.
- `ERR_POS`, 5: index of the corrupted play; effective only with `ERRO_INJ_EN`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `jogar`  in  1  request to start a run; sampled high for one cycle.
- `pronto`  in  1  game finished (from game).
- `acertou`  in  1  game win flag (from game).
- `errou`  in  1  game loss flag (from game).
- `iniciar`  out  1  start pulse to game.
- `chaves`  out  4  one-hot play value to game, or 0.
- `fim`  out  1  run complete.
- `sucesso`  out  1  run ended with `pronto`&`acertou` after play N-1.
- `timeout`  out  1  run ended because `pronto` never arrived.
- `db_indice`  out  4  current play index.
- `db_estado`  out  4  state code.

## Operation
- All outputs are registered.
- Reset clears all outputs to 0. `db_estado` resets to OCIOSO (0).
- OCIOSO: all outputs 0. `jogar`=1 → INICIA.
- INICIA (1 cycle): `iniciar`=1, index cleared, flags cleared → PREPARA.
- PREPARA: `chaves`=0 for `PREP_CYC` cycles → APRESENTA.
- APRESENTA: `chaves`=ROM[index] for `HOLD_CYC` cycles → SOLTA.
- SOLTA: `chaves`=0 for `GAP_CYC` cycles.
  - If index==N-1 → AGUARDA.
  - Otherwise index+1 → APRESENTA.
- AGUARDA: `chaves`=0, timeout counter running.
  - `pronto`&`acertou` → FIM_OK.
  - `pronto`&`errou` → FIM_ERRO.
  - Counter reaches `TIMEOUT_CYC` → FIM_ERRO with `timeout`=1.
- Early termination, in PREPARA, APRESENTA or SOLTA:
  - `pronto`&`errou` → FIM_ERRO.
  - `pronto`&`acertou` before index N-1 completes → FIM_ERRO (premature win).
  - In both cases `chaves` is forced to 0 in the next cycle.
- If `pronto` arrives with both or neither flag set, the run is treated as FIM_ERRO.
- FIM_OK: `fim`=1, `sucesso`=1. FIM_ERRO: `fim`=1, `sucesso`=0.
  - Both hold until `jogar`=1 → INICIA (restart, flags cleared).
- `jogar` is ignored in all other states.
- ROM contents, index 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Index width is 4 bits; the index never wraps, because the compare against N-1 precedes the increment.
- Asynchronous `reset` mid-run returns to OCIOSO immediately; `chaves` and `iniciar` drop to 0 without waiting for a clock edge.

## Timing
- `jogar` sampled at edge k → `iniciar` high during cycle k+1 only.
- First nonzero `chaves` appears in cycle k+2+`PREP_CYC`.
- Each play occupies `HOLD_CYC`+`GAP_CYC` cycles. Play i begins at k+2+`PREP_CYC`+i·(`HOLD_CYC`+`GAP_CYC`).
- AGUARDA is entered k+2+`PREP_CYC`+N·(`HOLD_CYC`+`GAP_CYC`).
- `fim` rises one cycle after the decisive `pronto` sample.
- Timeout: `fim` rises `TIMEOUT_CYC`+1 cycles after AGUARDA entry.
- All inputs are sampled on the rising edge of `clock`. The game is synchronous to the same clock, so no synchronizers are used.

## Configuration
- `JOGADOR_ERRO_INJ_EN` defined:
  - The play at index `ERR_POS` is replaced by ROM[`ERR_POS`] rotated left by 1 (e.g. 0010→0100).
  - Purpose: deliberately exercise the game's `errou` path.
- `JOGADOR_ERRO_INJ_EN` undefined:
  - ROM values are used unaltered.
  - `ERR_POS` is ignored and adds no logic.

## Structure
- Package `jogador_pkg`:
  - State codes: OCIOSO=0, INICIA=1, PREPARA=2, APRESENTA=3, SOLTA=4, AGUARDA=5, FIM_OK=6, FIM_ERRO=7.
  - ROM depth constant (16).
  - Default timing constants.
- Sub-module `sequencia_rom_16x4`: combinational 4-bit address → 4-bit one-hot data.
- Top level contains the FSM, the index counter, and one shared cycle counter (reused for PREPARA/HOLD/GAP/timeout).

## Test plan
- Reset, then `jogar` pulse against a correct game model → `iniciar` single cycle; 16 plays in ROM order each held 3 cycles; `fim`=1, `sucesso`=1, `timeout`=0.
- Game model asserts `pronto`&`errou` during play 3 → `chaves`=0 next cycle; `fim`=1, `sucesso`=0; `db_indice`=3.
- Game model never asserts `pronto` → `fim`=1, `timeout`=1 exactly 65 cycles after AGUARDA entry.
- Asynchronous `reset` during play 7 → `chaves`=0 and `db_estado`=0 immediately; a new `jogar` restarts from index 0.
- `jogar` pulsed during APRESENTA → ignored. `jogar` in FIM_OK → restart with flags cleared.
- With `JOGADOR_ERRO_INJ_EN` and `ERR_POS`=5 → play 5 drives 0100 instead of 0010; the game reports `errou`; `sucesso`=0.
